// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one cacheline adapter between the instruction cache
// and the data cache; one transaction in flight at a time, all adapter outputs registered.
module mem_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icache_read,
    input  logic [31:0]      icache_addr,
    output logic [255:0]     icache_rdata,
    output logic             icache_resp,
    input  logic             dcache_read,
    input  logic             dcache_write,
    input  logic [31:0]      dcache_addr,
    input  logic [255:0]     dcache_wdata,
    output logic [255:0]     dcache_rdata,
    output logic             dcache_resp,
    output logic             adp_read_enable,
    output logic             adp_write_enable,
    output logic [31:0]      adp_addr,
    output logic [255:0]     adp_write_data,
    input  logic [255:0]     adp_data_out,
    input  logic             adp_valid_out,
    output logic             timeout_err,
    output logic [CNT_W-1:0] icache_grants,
    output logic [CNT_W-1:0] dcache_grants
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP, GAP} state_t;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     LINE_MASK = 32'hFFFF_FFE0;

    state_t          state;
    logic            last_served_d;
    logic [TO_W-1:0] to_cnt;
    logic            dcache_pend;
    logic            grant_i;
    logic            grant_d;

    // On a tie the requester that was not served last wins.
    assign dcache_pend = dcache_read | dcache_write;
    assign grant_i     = icache_read & (~dcache_pend | last_served_d);
    assign grant_d     = dcache_pend & (~icache_read | ~last_served_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_served_d    <= 1'b1;
            to_cnt           <= '0;
            adp_read_enable  <= 1'b0;
            adp_write_enable <= 1'b0;
            adp_addr         <= '0;
            adp_write_data   <= '0;
            icache_rdata     <= '0;
            dcache_rdata     <= '0;
            icache_resp      <= 1'b0;
            dcache_resp      <= 1'b0;
            timeout_err      <= 1'b0;
            icache_grants    <= '0;
            dcache_grants    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state           <= BUSY_I;
                        last_served_d   <= 1'b0;
                        icache_grants   <= icache_grants + CNT_W'(1);
                        adp_read_enable <= 1'b1;
                        adp_addr        <= icache_addr & LINE_MASK;
                        adp_write_data  <= '0;
                        to_cnt          <= '0;
                    end else if (grant_d) begin
                        state            <= BUSY_D;
                        last_served_d    <= 1'b1;
                        dcache_grants    <= dcache_grants + CNT_W'(1);
                        // Read and write together is treated as a write.
                        adp_write_enable <= dcache_write;
                        adp_read_enable  <= ~dcache_write;
                        adp_addr         <= dcache_addr & LINE_MASK;
                        adp_write_data   <= dcache_wdata;
                        to_cnt           <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (adp_valid_out) begin
                        adp_read_enable  <= 1'b0;
                        adp_write_enable <= 1'b0;
                        state            <= RESP;
                        if (state == BUSY_I) begin
                            icache_rdata <= adp_data_out;
                            icache_resp  <= 1'b1;
                        end else begin
                            dcache_resp <= 1'b1;
                            if (!adp_write_enable)
                                dcache_rdata <= adp_data_out;
                        end
                    end else if (to_cnt != TO_MAX) begin
                        // Saturating wait counter; the error is sticky until reset.
                        to_cnt <= to_cnt + TO_W'(1);
                        if (to_cnt == TO_LAST)
                            timeout_err <= 1'b1;
                    end
                end
                RESP: begin
                    icache_resp <= 1'b0;
                    dcache_resp <= 1'b0;
                    state       <= GAP;
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter: one task per scenario,
// inputs driven and outputs sampled on the falling clock edge.
module tb_mem_req_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_read;
    logic [31:0]  icache_addr;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [31:0]  dcache_addr;
    logic [255:0] dcache_wdata;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic         adp_read_enable;
    logic         adp_write_enable;
    logic [31:0]  adp_addr;
    logic [255:0] adp_write_data;
    logic [255:0] adp_data_out;
    logic         adp_valid_out;
    logic         timeout_err;
    logic [31:0]  icache_grants;
    logic [31:0]  dcache_grants;

    int n_cmp = 0;
    int n_bad = 0;

    mem_req_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_addr(icache_addr),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .adp_read_enable(adp_read_enable), .adp_write_enable(adp_write_enable),
        .adp_addr(adp_addr), .adp_write_data(adp_write_data),
        .adp_data_out(adp_data_out), .adp_valid_out(adp_valid_out),
        .timeout_err(timeout_err),
        .icache_grants(icache_grants), .dcache_grants(dcache_grants)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        icache_read = 0; icache_addr = '0;
        dcache_read = 0; dcache_write = 0; dcache_addr = '0; dcache_wdata = '0;
        adp_data_out = '0; adp_valid_out = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for an adapter enable; returns at the negedge it is seen.
    task automatic wait_grant(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (adp_read_enable || adp_write_enable) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL grant_timeout: no adapter enable within 20 cycles, required one");
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if ({adp_read_enable, adp_write_enable, icache_resp, dcache_resp, timeout_err} !== 5'b0 ||
            adp_addr !== '0 || adp_write_data !== '0 || icache_rdata !== '0 ||
            dcache_rdata !== '0 || icache_grants !== 0 || dcache_grants !== 0) begin
            n_bad++;
            $display("FAIL %s: en=%b%b resp=%b%b err=%b addr=%h ig=%0d dg=%0d, required all zero",
                     tag, adp_read_enable, adp_write_enable, icache_resp, dcache_resp,
                     timeout_err, adp_addr, icache_grants, dcache_grants);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_all_zero("reset_values");
    endtask

    task automatic test_icache_read();
        do_reset();
        icache_read = 1; icache_addr = 32'h0000_1234;
        @(negedge clk);
        n_cmp++;
        if (adp_read_enable !== 1'b1 || adp_write_enable !== 1'b0 || adp_addr !== 32'h0000_1220) begin
            n_bad++;
            $display("FAIL ird_issue: rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=00001220",
                     adp_read_enable, adp_write_enable, adp_addr);
        end
        n_cmp++;
        if (icache_grants !== 32'd1 || dcache_grants !== 32'd0) begin
            n_bad++;
            $display("FAIL ird_grants: ig=%0d dg=%0d, required 1 and 0", icache_grants, dcache_grants);
        end
        adp_valid_out = 1; adp_data_out = {32{8'hAA}};
        @(negedge clk);
        adp_valid_out = 0; adp_data_out = '0; icache_read = 0;
        n_cmp++;
        if (icache_resp !== 1'b1 || dcache_resp !== 1'b0 || icache_rdata !== {32{8'hAA}}) begin
            n_bad++;
            $display("FAIL ird_resp: iresp=%b dresp=%b rdata=%h, required 1 0 AA..AA",
                     icache_resp, dcache_resp, icache_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (icache_resp !== 1'b0 || adp_read_enable !== 1'b0 || icache_rdata !== {32{8'hAA}}) begin
            n_bad++;
            $display("FAIL ird_gap: iresp=%b rd=%b rdata=%h, required 0 0 AA..AA",
                     icache_resp, adp_read_enable, icache_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr [3];
        bit ok;
        exp_addr = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0100};
        do_reset();
        icache_read = 1; icache_addr = 32'h0000_0100;
        dcache_read = 1; dcache_addr = 32'h0000_0200;
        for (int t = 0; t < 3; t++) begin
            wait_grant(ok);
            if (!ok) return;
            n_cmp++;
            if (adp_addr !== exp_addr[t]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: addr=%h, required %h", t, adp_addr, exp_addr[t]);
            end
            adp_valid_out = 1; adp_data_out = {8{t[31:0]}};
            @(negedge clk);
            adp_valid_out = 0;
            n_cmp++;
            if (icache_resp !== (t != 1) || dcache_resp !== (t == 1)) begin
                n_bad++;
                $display("FAIL rr_resp[%0d]: iresp=%b dresp=%b, required %b %b",
                         t, icache_resp, dcache_resp, t != 1, t == 1);
            end
        end
        n_cmp++;
        if (icache_grants !== 32'd2 || dcache_grants !== 32'd1) begin
            n_bad++;
            $display("FAIL rr_counts: ig=%0d dg=%0d, required 2 and 1", icache_grants, dcache_grants);
        end
        icache_read = 0; dcache_read = 0;
    endtask

    task automatic test_dcache_write();
        logic [255:0] wd;
        bit ok;
        bit stable;
        wd = {8{32'h0123_4567}};
        do_reset();
        dcache_write = 1; dcache_addr = 32'h8000_0040; dcache_wdata = wd;
        wait_grant(ok);
        if (!ok) return;
        // Change the requester's inputs; the adapter side must not follow.
        dcache_wdata = '1; dcache_addr = 32'h1111_1111;
        stable = 1;
        for (int i = 0; i < 4; i++) begin
            if (adp_write_enable !== 1'b1 || adp_read_enable !== 1'b0 ||
                adp_addr !== 32'h8000_0040 || adp_write_data !== wd)
                stable = 0;
            @(negedge clk);
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL dwr_hold: wr=%b rd=%b addr=%h, required held 1 0 80000040 with wdata",
                     adp_write_enable, adp_read_enable, adp_addr);
        end
        adp_valid_out = 1; adp_data_out = {32{8'h5A}};
        @(negedge clk);
        adp_valid_out = 0; dcache_write = 0;
        n_cmp++;
        if (dcache_resp !== 1'b1 || icache_resp !== 1'b0 || adp_write_enable !== 1'b0 ||
            dcache_rdata !== '0) begin
            n_bad++;
            $display("FAIL dwr_resp: dresp=%b iresp=%b wr=%b rdata=%h, required 1 0 0 and rdata 0",
                     dcache_resp, icache_resp, adp_write_enable, dcache_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (dcache_resp !== 1'b0 || adp_write_enable !== 1'b0 || adp_read_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL dwr_gap: dresp=%b wr=%b rd=%b, required all 0",
                     dcache_resp, adp_write_enable, adp_read_enable);
        end
    endtask

    task automatic test_drop_request();
        bit ok;
        bit quiet;
        do_reset();
        icache_read = 1; icache_addr = 32'h0000_4000;
        wait_grant(ok);
        if (!ok) return;
        @(negedge clk);
        @(negedge clk);
        icache_read = 0;
        @(negedge clk);
        n_cmp++;
        if (adp_read_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_hold: rd=%b, required 1", adp_read_enable);
        end
        adp_valid_out = 1; adp_data_out = {32{8'h3C}};
        @(negedge clk);
        adp_valid_out = 0;
        n_cmp++;
        if (icache_resp !== 1'b1 || icache_rdata !== {32{8'h3C}}) begin
            n_bad++;
            $display("FAIL drop_resp: iresp=%b rdata=%h, required 1 3C..3C", icache_resp, icache_rdata);
        end
        quiet = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (adp_read_enable || adp_write_enable || icache_resp) quiet = 0;
        end
        n_cmp++;
        if (!quiet || icache_grants !== 32'd1) begin
            n_bad++;
            $display("FAIL drop_nogrant: quiet=%b ig=%0d, required 1 and 1", quiet, icache_grants);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        dcache_read = 1; dcache_addr = 32'h0000_0080;
        wait_grant(ok);
        if (!ok) return;
        dcache_read = 0;
        repeat (15) @(negedge clk);
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL to_early: err=%b after 15 busy cycles, required 0", timeout_err);
        end
        @(negedge clk);
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL to_set: err=%b after 16 busy cycles, required 1", timeout_err);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (timeout_err !== 1'b1 || adp_read_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL to_sticky: err=%b rd=%b, required 1 1", timeout_err, adp_read_enable);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_all_zero("to_reset");
        icache_read = 1; icache_addr = 32'h0000_0020;
        @(negedge clk);
        n_cmp++;
        if (adp_read_enable !== 1'b1 || adp_addr !== 32'h0000_0020) begin
            n_bad++;
            $display("FAIL to_idle_after_rst: rd=%b addr=%h, required 1 00000020",
                     adp_read_enable, adp_addr);
        end
        icache_read = 0;
    endtask

    task automatic test_read_write_both();
        bit ok;
        do_reset();
        dcache_read = 1; dcache_write = 1; dcache_addr = 32'h0000_0C1F;
        dcache_wdata = {16{16'hBEEF}};
        wait_grant(ok);
        if (!ok) return;
        n_cmp++;
        if (adp_write_enable !== 1'b1 || adp_read_enable !== 1'b0 || adp_addr !== 32'h0000_0C00) begin
            n_bad++;
            $display("FAIL rw_both: wr=%b rd=%b addr=%h, required 1 0 00000C00",
                     adp_write_enable, adp_read_enable, adp_addr);
        end
        adp_valid_out = 1;
        @(negedge clk);
        adp_valid_out = 0; dcache_read = 0; dcache_write = 0;
        n_cmp++;
        if (dcache_resp !== 1'b1 || dcache_grants !== 32'd1) begin
            n_bad++;
            $display("FAIL rw_resp: dresp=%b dg=%0d, required 1 and 1", dcache_resp, dcache_grants);
        end
    endtask

    initial begin
        rst = 1;
        test_reset();
        test_icache_read();
        test_round_robin();
        test_dcache_write();
        test_drop_request();
        test_timeout();
        test_read_write_both();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
